fetch_unit: RTL

Instruction-fetch stage directly upstream of the instruction ROM. Holds the program counter and drives the ROM address. Captures the asynchronous ROM read data into a small instruction buffer. Presents {instruction, pc} to decode over a valid/ready handshake, and accepts redirects (taken branch / jump) that flush the buffer.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: FSM state enum, PC increment, default widths and the buffer entry layout.
// Ports: none (package).
// Optional feature macro: FETCH_ALIGN_CHECK_EN (makes ERR reachable in fetch_unit).
package fetch_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_INS_WIDTH     = 32;
  localparam int PC_STEP           = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FULL = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  // Buffer entry at the default widths; fetch_unit declares the same layout
  // at its own parameterised widths.
  typedef struct packed {
    logic [DEF_INS_WIDTH-1:0]     instr;
    logic [DEF_ADDRESS_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush
// Purpose: DEPTH-entry FIFO; flush beats push and pop; head read straight from registers.
// Ports: clk, rst (async active-high), push_i, pop_i, flush_i, wdata_i,
//        rdata_o (head), count_o, full_o, empty_o.
module fetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, ROM address, buffer and decode handshake
// Purpose: drives rom_addr from the PC, buffers {rom_data, pc}, presents the head to decode
//          over valid/ready, and flushes/reloads on redirect.
// Ports: clk, rst (async active-high); rom_addr/rom_data (ROM side);
//        redirect_valid/redirect_target; instr_valid/instr_ready/instr/instr_pc (decode side);
//        fetch_err (misaligned redirect, sticky).
// Optional feature macro: FETCH_ALIGN_CHECK_EN - misaligned redirects raise fetch_err and
//        park the unit in ERR; when undefined, redirect targets are word-aligned by masking.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int          INS_WIDTH     = DEF_INS_WIDTH,
  parameter int          FIFO_DEPTH    = 2,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [INS_WIDTH-1:0]     rom_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INS_WIDTH-1:0]     instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     fetch_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INS_WIDTH-1:0]     instr;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     push, pop, flush;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  entry_t                   wr_entry, head;

  assign rom_addr    = pc_q;
  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign wr_entry    = '{instr: rom_data, pc: pc_q};

  assign pop  = instr_valid && instr_ready;
  // In FULL a new word only enters when the head leaves; redirect and ERR suppress fetch.
  assign push = ((state_q == RUN && !fifo_full) || pop) && !redirect_valid && (state_q != ERR);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign fetch_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    if (redirect_valid) begin
      // The head is discarded, so a concurrent pop has no effect.
      flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (state_q == ERR) begin
        state_d = ERR;
      end else if (misaligned) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        pc_d    = redirect_target;
        state_d = RUN;
      end
`else
      pc_d    = redirect_target & ~ADDRESS_WIDTH'(3);
      state_d = RUN;
`endif
    end else begin
      if (push) pc_d = pc_q + ADDRESS_WIDTH'(PC_STEP);
      unique case (state_q)
        RUN:     if (push && !pop && fifo_count == CW'(FIFO_DEPTH - 1)) state_d = FULL;
        FULL:    if (pop && !push) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= ADDRESS_WIDTH'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(INS_WIDTH + ADDRESS_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
